// File: rtl/slu_pkg.sv
// slu_pkg: shared constants for the relay-card register file.
//   Address map constants and bit positions inside the status/control
//   register, used by slu_regfile.
package slu_pkg;

    localparam logic [7:0] ADDR_TYPE   = 8'h00;
    localparam logic [7:0] ADDR_CFG    = 8'h01;
    localparam logic [7:0] ADDR_STAT   = 8'h02;
    localparam logic [7:0] ADDR_RELAY0 = 8'h03;

    // Status read layout: {busy, err, 5'b0, pending}
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_ERR_BIT  = 6;
    localparam int STAT_BUSY_BIT = 7;

    // Control write bits
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_DISCARD_BIT = 1;

endpackage

// File: rtl/slu_strobe_sync.sv
// slu_strobe_sync: brings the asynchronous bus strobe into the clk domain
// and produces a one-cycle pulse per rising edge.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   strobe      : asynchronous bus strobe
//   strobe_rise : one-cycle pulse, high 3 clk after the strobe edge
module slu_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic strobe_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic primed_q, primed_d;
    logic armed_q, armed_d;
    logic rise_q, rise_d;

    // The synchronizer clears to 0, which would otherwise look like a rising
    // edge if strobe is already high when reset releases. Edges are only
    // accepted once strobe has been observed low after reset.
    always_comb begin
        sync1_d  = strobe;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        primed_d = 1'b1;
        armed_d  = armed_q | (primed_q & ~sync1_q);
        rise_d   = sync2_q & ~sync3_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            primed_q <= primed_d;
            armed_q  <= armed_d;
            rise_q   <= rise_d;
        end
    end

    assign strobe_rise = rise_q;

endmodule

// File: rtl/slu_regfile.sv
// slu_regfile: register file of a relay-drive card on an asynchronous
// strobe bus. Host writes go to staging bytes; a commit copies staging
// into the active relay image and runs a settle timer.
//   clk, reset : system clock, synchronous active-high reset
//   strobe     : asynchronous bus strobe, one access per rising edge
//   rw_n       : 1 = host read (card drives data_bus), 0 = host write
//   address    : byte address
//   data_bus   : bidirectional data, driven with the read register on reads
//   memory     : active relay image, byte k at [8k+7:8k]
//   busy       : high while the settle timer runs
module slu_regfile
    import slu_pkg::*;
#(
    parameter int         NUM_BYTES     = 8,
    parameter logic [7:0] CARD_TYPE     = 8'h43,
    parameter logic [7:0] CARD_CONFIG   = 8'h0F,
    parameter int         SETTLE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   strobe,
    input  logic                   rw_n,
    input  logic [7:0]             address,
    inout  wire  [7:0]             data_bus,
    output logic [8*NUM_BYTES-1:0] memory,
    output logic                   busy
);

    localparam int            CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

    logic                   strobe_rise;
    logic [7:0]             stage_q [NUM_BYTES];
    logic [7:0]             stage_d [NUM_BYTES];
    logic [7:0]             mem_q   [NUM_BYTES];
    logic [7:0]             mem_d   [NUM_BYTES];
    logic [8*NUM_BYTES-1:0] stage_flat;
    logic [7:0]             rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          timer_q, timer_d;
    logic                   pending;
    logic [8:0]             rel_off;
    logic                   relay_hit;
    logic [7:0]             relay_rd;
    logic [7:0]             status_rd;
    logic [7:0]             wr_data;

    slu_strobe_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .strobe      (strobe),
        .strobe_rise (strobe_rise)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_flat
            assign memory[8*gi +: 8]     = mem_q[gi];
            assign stage_flat[8*gi +: 8] = stage_q[gi];
        end
    endgenerate

    assign busy     = (timer_q != '0);
    assign pending  = (stage_flat != memory);
    assign wr_data  = data_bus;
    assign data_bus = rw_n ? rdata_q : 8'hzz;

    // 9-bit offset so addresses below the relay window wrap out of range
    assign rel_off   = {1'b0, address} - {1'b0, ADDR_RELAY0};
    assign relay_hit = (address >= ADDR_RELAY0) && (rel_off < 9'(NUM_BYTES));

    always_comb begin
        status_rd                = 8'h00;
        status_rd[STAT_BUSY_BIT] = busy;
        status_rd[STAT_ERR_BIT]  = err_q;
        status_rd[STAT_PEND_BIT] = pending;

        relay_rd = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (rel_off == 9'(i)) relay_rd = stage_q[i];
        end
    end

    always_comb begin
        stage_d = stage_q;
        mem_d   = mem_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = busy ? (timer_q - CW'(1)) : timer_q;

        if (strobe_rise) begin
            if (rw_n) begin
                case (address)
                    ADDR_TYPE: rdata_d = CARD_TYPE;
                    ADDR_CFG:  rdata_d = CARD_CONFIG;
                    ADDR_STAT: begin
                        rdata_d = status_rd;
                        err_d   = 1'b0;
                    end
                    default:   rdata_d = relay_hit ? relay_rd : 8'h00;
                endcase
            end else if (address == ADDR_STAT) begin
                // Discard wins over commit when both bits are set
                if (wr_data[CTRL_DISCARD_BIT]) begin
                    stage_d = mem_q;
                end else if (wr_data[CTRL_COMMIT_BIT]) begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        mem_d   = stage_q;
                        timer_d = SETTLE_LOAD;
                    end
                end
            end else if (relay_hit) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (rel_off == 9'(i)) stage_d[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                stage_q[i] <= 8'h00;
                mem_q[i]   <= 8'h00;
            end
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            stage_q <= stage_d;
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: doc/slu_regfile.md
SLU_REGFILE -- requirements
Module: slu_regfile

Interface
REQ-001 Parameter NUM_BYTES, default 8: number of relay-drive bytes, range 1..252.
REQ-002 Parameter CARD_TYPE, default 8'h43: value returned at address 0x00.
REQ-003 Parameter CARD_CONFIG, default 8'h0F: value returned at address 0x01.
REQ-004 Parameter SETTLE_CYCLES, default 1000: relay settle time in clk cycles, minimum 1.
REQ-005 Port clk, input, 1: single system clock; all state SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port strobe, input, 1: asynchronous bus strobe; each rising edge is one bus access.
REQ-008 Port rw_n, input, 1: high = card drives bus (host read); low = card samples bus (host write).
REQ-009 Port address, input, 8: byte address, stable while strobe is high.
REQ-010 Port data_bus, inout, 8: driven with the read register when rw_n is high, else high-Z.
REQ-011 Port memory, output, 8*NUM_BYTES: active relay image; byte k at bits [8k+7:8k].
REQ-012 Port busy, output, 1: high while the settle timer runs.

Function
REQ-013 strobe SHALL pass a 2-flop synchronizer and rising-edge detector; an access executes on the cycle the edge pulse is high (3 clk after the strobe edge).
REQ-014 address, rw_n and data_bus SHALL be sampled on the edge-pulse cycle.
REQ-015 Address map: 0x00 CARD_TYPE (RO); 0x01 CARD_CONFIG (RO); 0x02 status/control; 0x03..0x03+NUM_BYTES-1 staging bytes (RW).
REQ-016 Status read SHALL return {busy, err, 5'b0, pending}: pending = staging differs from memory, err = sticky commit-rejected flag.
REQ-017 A read of status SHALL clear err on the same cycle; an err set on that same cycle SHALL win.
REQ-018 Staging reads SHALL return the staging byte; reads of unmapped addresses SHALL return 8'h00.
REQ-019 The read register SHALL load on the edge-pulse cycle and hold until the next read access.
REQ-020 Writes to 0x00, 0x01 and unmapped addresses SHALL be ignored.
REQ-021 Staging writes SHALL update staging only; memory SHALL be unaffected.
REQ-022 A status write with bit0=1 while busy is low SHALL copy staging into memory on the next cycle and start the settle timer.
REQ-023 A status write with bit0=1 while busy is high SHALL be ignored and SHALL set err.
REQ-024 A status write with bit1=1 SHALL copy memory into staging (discard staging) and take priority over bit0 in the same write.
REQ-025 The timer SHALL load SETTLE_CYCLES on commit and count down once per clk; busy SHALL be high exactly SETTLE_CYCLES cycles, starting the cycle memory changes.
REQ-026 Staging writes during busy SHALL be accepted.
REQ-027 Counter width SHALL be $clog2(SETTLE_CYCLES+1); the counter SHALL not wrap below 0.

Reset
REQ-028 On reset: memory, staging, the read register, err and the timer SHALL be 0, and busy SHALL be 0.
REQ-029 On reset the synchronizer flops SHALL be 0, so a strobe already high at reset release does not generate an access.
REQ-030 Reset asserted mid-settle SHALL abort the timer; busy SHALL be low on the first cycle after reset.

Structure
REQ-031 Package slu_pkg SHALL hold the address constants (ADDR_TYPE, ADDR_CFG, ADDR_STAT, ADDR_RELAY0) and status bit indices.
REQ-032 Synchronizer and edge detector SHALL be sub-module slu_strobe_sync (inputs clk, reset, strobe; output strobe_rise).

Verification
REQ-033 Reset, then read 0x00 and 0x01 -> data_bus 8'h43, then 8'h0F; memory 0; busy 0.
REQ-034 Write 8'hA5 to 0x03, then read 0x02 -> 8'h01; memory 0; read 0x03 -> 8'hA5.
REQ-035 Commit (write 8'h01 to 0x02) -> memory[7:0]=8'hA5 one cycle after the pulse; busy high for exactly SETTLE_CYCLES; then status 8'h00.
REQ-036 Commit again while busy -> memory unchanged; status 8'hC0 or 8'h40 (busy, err); a second status read clears err.
REQ-037 Write 8'h3C to 0x04, then write 8'h03 to 0x02 -> staging byte1 reverts to the memory value, no commit, busy stays 0; read 0xFF -> 8'h00.
REQ-038 Assert reset for 1 cycle mid-settle -> busy 0 and memory 0 on the next cycle; strobe held high across release -> no access.
